// File: rtl/avalon_burst_slave.sv
// Avalon-MM burst slave in front of a 2^ADDR_W x 32-bit single-port synchronous RAM.
// Define AVALON_SLAVE_BURST_EN to honour burstCount; otherwise every command is a single beat.
module avalon_burst_slave #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [3:0]  byteEnable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writeData,
    input  logic        beginBurstTransfer,
    input  logic [7:0]  burstCount,
    output logic [31:0] readData,
    output logic        readDataValid,
    output logic        waitRequest
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        remain;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] addr_idx;
    logic [ADDR_W-1:0] acc_idx;
    logic [7:0]        eff_len;
    logic              wr_en;
    logic              rd_en;
    logic              unused_bits;

    assign addr_idx = address[ADDR_W+1:2];

`ifdef AVALON_SLAVE_BURST_EN
    assign eff_len = (burstCount == 8'd0) ? 8'd1 : burstCount;
`else
    assign eff_len = 8'd1;
`endif

    // Burst marker and the byte/upper address bits carry no decode meaning here.
    assign unused_bits = ^{beginBurstTransfer, burstCount, address[31:ADDR_W+2], address[1:0]};

    // Commands use the bus address; burst beats after the first follow the internal pointer.
    assign acc_idx = (state == IDLE) ? addr_idx : ptr;
    assign wr_en   = !rst && write && (state != RD_BURST);
    assign rd_en   = !rst && (((state == IDLE) && read && !write) ||
                              ((state == RD_BURST) && (remain != 8'd0)));

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && byteEnable[b]) begin
                mem[acc_idx][8*b +: 8] <= writeData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readData <= '0;
        end else if (rd_en) begin
            readData <= mem[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            remain        <= '0;
            readDataValid <= 1'b0;
            waitRequest   <= 1'b0;
        end else begin
            readDataValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (write) begin
                        if (eff_len > 8'd1) begin
                            state  <= WR_BURST;
                            ptr    <= addr_idx + 1'b1;
                            remain <= eff_len - 8'd1;
                        end
                    end else if (read) begin
                        // First beat is fetched now; remain counts the beats still owed.
                        state         <= RD_BURST;
                        readDataValid <= 1'b1;
                        waitRequest   <= 1'b1;
                        ptr           <= addr_idx + 1'b1;
                        remain        <= eff_len - 8'd1;
                    end
                end
                WR_BURST: begin
                    if (write) begin
                        ptr    <= ptr + 1'b1;
                        remain <= remain - 8'd1;
                        if (remain == 8'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    if (remain != 8'd0) begin
                        readDataValid <= 1'b1;
                        ptr           <= ptr + 1'b1;
                        remain        <= remain - 8'd1;
                    end else begin
                        state       <= IDLE;
                        waitRequest <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    waitRequest <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_burst_slave.sv
// Bench for avalon_burst_slave: randomized traffic against a transaction-level model, plus pinned literals.
// Honours AVALON_SLAVE_BURST_EN the same way the design does.
module tb_avalon_burst_slave;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef AVALON_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0;
    logic [3:0]  byteEnable = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writeData = '0;
    logic        beginBurstTransfer = 1'b0;
    logic [7:0]  burstCount = '0;
    logic [31:0] readData;
    logic        readDataValid;
    logic        waitRequest;

    avalon_burst_slave #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .address(address), .byteEnable(byteEnable),
        .read(read), .write(write), .writeData(writeData),
        .beginBurstTransfer(beginBurstTransfer), .burstCount(burstCount),
        .readData(readData), .readDataValid(readDataValid), .waitRequest(waitRequest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: memory image and the one outstanding read window.
    logic [31:0] mem_m [DEPTH];
    int          rd_start = 0;
    int          rd_n = 0;
    int          rd_base = 0;
    logic [31:0] last_exp = '0;
    bit          ev;
    bit          rst_seen = 1'b1;
    bit          chk_en = 1'b0;
    int          vld_count = 0;
    int          checks = 0;
    int          errors = 0;

    int          lit_seq = 0;
    int          lit_done = 0;
    int          lit_kind = 0;
    int          lit_base = 0;
    logic [31:0] lit_exp = '0;
    string       lit_name = "";

    logic [31:0] wdat [16];
    logic [3:0]  wbe  [16];

    function automatic int eff(input int bc);
        return (BURST && bc != 0) ? bc : 1;
    endfunction

    function automatic logic [31:0] mk_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[ADDR_W+1:2] = idx[ADDR_W-1:0];
        return a;
    endfunction

    function automatic int rand_idx();
        if ($urandom % 4 == 0) return DEPTH - 1 - int'($urandom % 4);
        return int'($urandom % DEPTH);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            ev = (cyc > rd_start) && (cyc <= rd_start + rd_n);
            if (rst_seen) last_exp = '0;
            check32("readDataValid", {31'b0, readDataValid}, {31'b0, ev});
            check32("waitRequest", {31'b0, waitRequest}, {31'b0, ev});
            if (ev) last_exp = mem_m[(rd_base + cyc - rd_start - 1) % DEPTH];
            if (readDataValid) vld_count++;
            check32("readData", readData, last_exp);
            if (lit_seq != lit_done) begin
                case (lit_kind)
                    0:       check32(lit_name, readData, lit_exp);
                    1:       check32(lit_name, 32'(vld_count - lit_base), lit_exp);
                    default: check32(lit_name, mem_m[lit_base], lit_exp);
                endcase
                lit_done = lit_seq;
            end
        end
        rst_seen = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input int kind, input string name, input int base, input logic [31:0] exp);
        lit_kind = kind;
        lit_name = name;
        lit_base = base;
        lit_exp  = exp;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be,
                              input logic [7:0] bc, input logic rd, input logic first);
        int idx;
        idx = int'(addr[ADDR_W+1:2]);
        address = addr; writeData = d; byteEnable = be; burstCount = bc;
        read = rd; write = 1'b1; beginBurstTransfer = first;
        for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
        tick();
        write = 1'b0; read = 1'b0; beginBurstTransfer = 1'b0;
    endtask

    task automatic do_wr_burst(input int base, input int n, input int stall_at, input int stall_len);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at && i > 0) repeat (stall_len) tick();
            drive_beat(mk_addr((base + i) % DEPTH), wdat[i], wbe[i],
                       (i == 0) ? 8'(n) : 8'($urandom),
                       (i == 0) ? 1'b0 : 1'($urandom % 2), i == 0);
        end
    endtask

    task automatic rd_issue(input logic [31:0] addr, input int bc);
        address = addr; burstCount = 8'(bc); read = 1'b1; beginBurstTransfer = 1'b1;
        byteEnable = 4'($urandom); writeData = $urandom;
        rd_base = int'(addr[ADDR_W+1:2]);
        rd_n = eff(bc);
        rd_start = cyc;
        tick();
        read = 1'b0; beginBurstTransfer = 1'b0;
    endtask

    task automatic do_rd(input logic [31:0] addr, input int bc);
        rd_issue(addr, bc);
        repeat (eff(bc)) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        lit(0, "reset_readData", 0, 32'h0);

        for (int i = 0; i < DEPTH; i++) drive_beat(mk_addr(i), $urandom, 4'hF, 8'd1, 1'b0, 1'b1);

        drive_beat(32'h10, 32'hA5A5_1234, 4'hF, 8'd1, 1'b0, 1'b1);
        do_rd(32'h10, 1);
        lit(0, "single_rw", 0, 32'hA5A5_1234);

        drive_beat(32'h20, 32'hFFFF_FFFF, 4'hF, 8'd1, 1'b0, 1'b1);
        drive_beat(32'h20, 32'h0000_0000, 4'h2, 8'd1, 1'b0, 1'b1);
        do_rd(32'h20, 1);
        lit(0, "byte_enable", 0, 32'hFFFF_00FF);

        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wbe[i] = 4'hF; end
        do_wr_burst(32'h40 >> 2, 4, 2, 2);
        base = vld_count;
        do_rd(32'h40, 4);
        lit(0, "burst4_last", 0, BURST ? 32'd4 : 32'd1);
        lit(1, "burst4_beats", base, BURST ? 32'd4 : 32'd1);
        lit(2, "model_word_0x44", 32'h44 >> 2, 32'd2);

        drive_beat(32'hFFC, 32'hAAAA_0001, 4'hF, 8'd1, 1'b0, 1'b1);
        drive_beat(32'h000, 32'hBBBB_0000, 4'hF, 8'd1, 1'b0, 1'b1);
        drive_beat(32'h004, 32'hCCCC_0001, 4'hF, 8'd1, 1'b0, 1'b1);
        base = vld_count;
        do_rd(32'hFFC, 3);
        lit(0, "wrap_last", 0, BURST ? 32'hCCCC_0001 : 32'hAAAA_0001);
        lit(1, "wrap_beats", base, BURST ? 32'd3 : 32'd1);
        lit(2, "model_word_1023", 1023, 32'hAAAA_0001);

        rd_issue(32'h80, 8);
        tick();
        rst = 1'b1;
        tick();
        rd_n = 0;
        rst = 1'b0;
        lit(0, "after_reset_readData", 0, 32'h0);
        do_rd(32'h10, 1);
        lit(0, "after_reset_read", 0, 32'hA5A5_1234);

        for (int it = 0; it < 80; it++) begin
            case ($urandom % 4)
                0: drive_beat(mk_addr(rand_idx()), $urandom, 4'($urandom), 8'($urandom % 2),
                              1'($urandom % 2), 1'b1);
                1: begin
                    n = 1 + int'($urandom % 6);
                    for (int i = 0; i < n; i++) begin wdat[i] = $urandom; wbe[i] = 4'($urandom); end
                    do_wr_burst(rand_idx(), n, int'($urandom % n), int'($urandom % 3));
                end
                2: do_rd(mk_addr(rand_idx()), int'($urandom % 7));
                default: repeat ($urandom % 3) tick();
            endcase
        end

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
